// File: rtl/id_ex_decode.sv
// id_ex_decode: RV32I-subset decode stage with a handshaked ID/EX register and load-use bubble insertion.
// Define ID_ILLEGAL_TRAP_EN to carry illegal instructions down the pipe flagged in ID_EX_illegal.
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_SLL  5'd2
`define ALU_SLT  5'd3
`define ALU_SLTU 5'd4
`define ALU_XOR  5'd5
`define ALU_SRL  5'd6
`define ALU_SRA  5'd7
`define ALU_OR   5'd8
`define ALU_AND  5'd9
`endif
`ifndef BUS_NONE
`define BUS_NONE  2'd0
`define BUS_READ  2'd1
`define BUS_WRITE 2'd2
`endif

module id_ex_decode #(
  parameter int XLEN = 32,
  parameter int NREG_BITS = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      RF_rs1_data,
  input  logic [XLEN-1:0]      RF_rs2_data,
  input  logic [XLEN-1:0]      IF_ID_pc,
  input  logic [31:0]          IF_ID_inst,
  input  logic                 IF_ID_vld,
  input  logic                 EX_ready,
  input  logic                 flush,
  output logic [NREG_BITS-1:0] ID_rs1,
  output logic [NREG_BITS-1:0] ID_rs2,
  output logic                 ID_stall,
  output logic                 ID_EX_vld,
  output logic [XLEN-1:0]      ID_EX_pc,
  output logic [XLEN-1:0]      ID_EX_alu_opa,
  output logic [XLEN-1:0]      ID_EX_alu_opb,
  output logic [4:0]           ID_EX_alu_func,
  output logic [XLEN-1:0]      ID_EX_mem_din,
  output logic [1:0]           ID_EX_mem_cmd,
  output logic [NREG_BITS-1:0] ID_EX_rd,
  output logic                 ID_EX_illegal
);
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic w_is_op, w_is_imm, w_is_lui, w_is_auipc, w_is_load, w_is_store, w_legal;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_u, w_shamt, w_opa, w_opb;
  logic [4:0] w_func, w_alu_f;
  logic [1:0] w_cmd;
  logic [NREG_BITS-1:0] w_rd;
  logic w_use1, w_use2, w_hz, w_adv, w_take, w_side, w_ill;
  logic r_vld, r_ill;
  logic [XLEN-1:0] r_pc, r_opa, r_opb, r_din;
  logic [4:0] r_func;
  logic [1:0] r_cmd;
  logic [NREG_BITS-1:0] r_rd;

  assign w_opc      = IF_ID_inst[6:0];
  assign w_f3       = IF_ID_inst[14:12];
  assign w_is_op    = w_opc == 7'b0110011;
  assign w_is_imm   = w_opc == 7'b0010011;
  assign w_is_lui   = w_opc == 7'b0110111;
  assign w_is_auipc = w_opc == 7'b0010111;
  assign w_is_load  = w_opc == 7'b0000011;
  assign w_is_store = w_opc == 7'b0100011;
  assign w_legal    = w_is_op | w_is_imm | w_is_lui | w_is_auipc | w_is_load | w_is_store;
  assign ID_rs1     = NREG_BITS'(IF_ID_inst[19:15]);
  assign ID_rs2     = NREG_BITS'(IF_ID_inst[24:20]);
  assign w_imm_i    = XLEN'($signed(IF_ID_inst[31:20]));
  assign w_imm_s    = XLEN'($signed({IF_ID_inst[31:25], IF_ID_inst[11:7]}));
  assign w_imm_u    = XLEN'($signed({IF_ID_inst[31:12], 12'b0}));
  assign w_shamt    = XLEN'(IF_ID_inst[24:20]);
  assign w_opa      = w_is_lui ? '0 : w_is_auipc ? IF_ID_pc : RF_rs1_data;
  assign w_opb      = w_is_op ? RF_rs2_data : (w_is_lui | w_is_auipc) ? w_imm_u : w_is_store ? w_imm_s :
                      (w_is_imm && w_f3[1:0] == 2'b01) ? w_shamt : w_imm_i;
  always_comb begin
    w_alu_f = `ALU_ADD;
    case (w_f3)
      3'd0: w_alu_f = (w_is_op & IF_ID_inst[30]) ? `ALU_SUB : `ALU_ADD;
      3'd1: w_alu_f = `ALU_SLL;
      3'd2: w_alu_f = `ALU_SLT;
      3'd3: w_alu_f = `ALU_SLTU;
      3'd4: w_alu_f = `ALU_XOR;
      3'd5: w_alu_f = IF_ID_inst[30] ? `ALU_SRA : `ALU_SRL;
      3'd6: w_alu_f = `ALU_OR;
      default: w_alu_f = `ALU_AND;
    endcase
  end
  assign w_func = (w_is_op | w_is_imm) ? w_alu_f : `ALU_ADD;
  assign w_cmd  = w_is_load ? `BUS_READ : w_is_store ? `BUS_WRITE : `BUS_NONE;
  assign w_rd   = w_is_store ? '0 : NREG_BITS'(IF_ID_inst[11:7]);
  assign w_use1 = w_is_op | w_is_imm | w_is_load | w_is_store;
  assign w_use2 = w_is_op | w_is_store;
  // rd of 0 never matches, so loads to x0 cannot stall anyone
  assign w_hz   = IF_ID_vld & r_vld & (r_cmd == `BUS_READ) & (r_rd != '0) &
                  ((w_use1 & (r_rd == ID_rs1)) | (w_use2 & (r_rd == ID_rs2)));
  assign w_adv  = !r_vld | EX_ready;
  assign ID_stall = !rst & IF_ID_vld & !flush & (w_hz | !w_adv);
  assign w_side = IF_ID_vld & w_legal;
`ifdef ID_ILLEGAL_TRAP_EN
  assign w_take = IF_ID_vld;
  assign w_ill  = IF_ID_vld & !w_legal;
`else
  assign w_take = w_side;
  assign w_ill  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_pc <= RESET_PC;
      r_opa <= '0;
      r_opb <= '0;
      r_func <= '0;
      r_din <= '0;
      r_cmd <= `BUS_NONE;
      r_rd <= '0;
      r_ill <= 1'b0;
    end else if (flush) begin
      r_vld <= 1'b0;
      r_cmd <= `BUS_NONE;
      r_ill <= 1'b0;
    end else if (w_adv & w_hz) begin
      r_vld <= 1'b0;
      r_cmd <= `BUS_NONE;
      r_rd <= '0;
      r_ill <= 1'b0;
    end else if (w_adv) begin
      r_vld <= w_take;
      r_pc <= IF_ID_pc;
      r_opa <= w_opa;
      r_opb <= w_opb;
      r_func <= w_func;
      r_din <= RF_rs2_data;
      r_cmd <= w_side ? w_cmd : `BUS_NONE;
      r_rd <= w_side ? w_rd : '0;
      r_ill <= w_ill;
    end
  end

  assign ID_EX_vld      = r_vld;
  assign ID_EX_pc       = r_pc;
  assign ID_EX_alu_opa  = r_opa;
  assign ID_EX_alu_opb  = r_opb;
  assign ID_EX_alu_func = r_func;
  assign ID_EX_mem_din  = r_din;
  assign ID_EX_mem_cmd  = r_cmd;
  assign ID_EX_rd       = r_rd;
  assign ID_EX_illegal  = r_ill;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: directed checks of decode, load-use bubbles, backpressure, flush and reset.
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_SLL  5'd2
`define ALU_SLT  5'd3
`define ALU_SLTU 5'd4
`define ALU_XOR  5'd5
`define ALU_SRL  5'd6
`define ALU_SRA  5'd7
`define ALU_OR   5'd8
`define ALU_AND  5'd9
`endif
`ifndef BUS_NONE
`define BUS_NONE  2'd0
`define BUS_READ  2'd1
`define BUS_WRITE 2'd2
`endif

module tb_id_ex_decode;
  logic clk = 0, rst = 1;
  logic [31:0] RF_rs1_data = 0, RF_rs2_data = 0, IF_ID_pc = 0, IF_ID_inst = 0;
  logic IF_ID_vld = 0, EX_ready = 1, flush = 0;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd, ID_EX_alu_func;
  logic ID_stall, ID_EX_vld, ID_EX_illegal;
  logic [31:0] ID_EX_pc, ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_mem_din;
  logic [1:0] ID_EX_mem_cmd;
  int pass = 0, total = 0;

  id_ex_decode #(.XLEN(32), .NREG_BITS(5), .RESET_PC(32'h80)) dut (
    .clk(clk), .rst(rst), .RF_rs1_data(RF_rs1_data), .RF_rs2_data(RF_rs2_data),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_vld(IF_ID_vld),
    .EX_ready(EX_ready), .flush(flush), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_stall(ID_stall), .ID_EX_vld(ID_EX_vld), .ID_EX_pc(ID_EX_pc),
    .ID_EX_alu_opa(ID_EX_alu_opa), .ID_EX_alu_opb(ID_EX_alu_opb),
    .ID_EX_alu_func(ID_EX_alu_func), .ID_EX_mem_din(ID_EX_mem_din),
    .ID_EX_mem_cmd(ID_EX_mem_cmd), .ID_EX_rd(ID_EX_rd), .ID_EX_illegal(ID_EX_illegal));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    IF_ID_inst = inst; IF_ID_pc = pc; RF_rs1_data = a; RF_rs2_data = b; IF_ID_vld = 1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(32'hFFD08293, 32'h44, 32'h10, 32'h20);
    tick; tick;
    total++; if (ID_EX_vld !== 1'b0) $display("FAIL rst_vld got %0h want 0", ID_EX_vld); else pass++;
    total++; if (ID_EX_pc !== 32'h80) $display("FAIL rst_pc got %0h want 80", ID_EX_pc); else pass++;
    total++; if (ID_EX_mem_cmd !== `BUS_NONE) $display("FAIL rst_cmd got %0h want 0", ID_EX_mem_cmd); else pass++;
    total++; if ({ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_mem_din} !== 96'h0) $display("FAIL rst_data got %0h want 0", {ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_mem_din}); else pass++;
    total++; if ({ID_EX_alu_func, ID_EX_rd, ID_EX_illegal} !== 11'h0) $display("FAIL rst_ctl got %0h want 0", {ID_EX_alu_func, ID_EX_rd, ID_EX_illegal}); else pass++;
    total++; if (ID_stall !== 1'b0) $display("FAIL rst_stall got %0h want 0", ID_stall); else pass++;
    rst = 0;
  endtask

  task automatic test_addi;
    drive(32'hFFD08293, 32'h100, 32'h10, 32'h0);
    total++; if (ID_rs1 !== 5'd1) $display("FAIL addi_rs1 got %0d want 1", ID_rs1); else pass++;
    tick;
    total++; if (ID_EX_vld !== 1'b1) $display("FAIL addi_vld got %0h want 1", ID_EX_vld); else pass++;
    total++; if (ID_EX_alu_opa !== 32'h10) $display("FAIL addi_opa got %0h want 10", ID_EX_alu_opa); else pass++;
    total++; if (ID_EX_alu_opb !== 32'hFFFFFFFD) $display("FAIL addi_opb got %0h want fffffffd", ID_EX_alu_opb); else pass++;
    total++; if (ID_EX_alu_func !== `ALU_ADD) $display("FAIL addi_func got %0h want 0", ID_EX_alu_func); else pass++;
    total++; if (ID_EX_rd !== 5'd5) $display("FAIL addi_rd got %0d want 5", ID_EX_rd); else pass++;
    total++; if (ID_EX_pc !== 32'h100) $display("FAIL addi_pc got %0h want 100", ID_EX_pc); else pass++;
  endtask

  task automatic test_alu_ops;
    drive(32'h40220333, 32'h104, 32'h9, 32'h4);
    tick;
    total++; if ({ID_EX_alu_func, ID_EX_rd, ID_EX_alu_opb} !== {`ALU_SUB, 5'd6, 32'h4}) $display("FAIL sub got %0h want %0h", {ID_EX_alu_func, ID_EX_rd, ID_EX_alu_opb}, {`ALU_SUB, 5'd6, 32'h4}); else pass++;
    drive(32'h4030D413, 32'h108, 32'h9, 32'h4);
    tick;
    total++; if ({ID_EX_alu_func, ID_EX_alu_opb} !== {`ALU_SRA, 32'h3}) $display("FAIL srai got %0h want %0h", {ID_EX_alu_func, ID_EX_alu_opb}, {`ALU_SRA, 32'h3}); else pass++;
    drive(32'h00001517, 32'h10C, 32'h9, 32'h4);
    tick;
    total++; if ({ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_rd} !== {32'h10C, 32'h1000, 5'd10}) $display("FAIL auipc got %0h want %0h", {ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_rd}, {32'h10C, 32'h1000, 5'd10}); else pass++;
  endtask

  task automatic test_load_use;
    drive(32'h00412183, 32'h110, 32'h20, 32'h0);
    total++; if (ID_stall !== 1'b0) $display("FAIL lw_stall got %0h want 0", ID_stall); else pass++;
    tick;
    total++; if ({ID_EX_vld, ID_EX_mem_cmd, ID_EX_rd, ID_EX_alu_opb} !== {1'b1, `BUS_READ, 5'd3, 32'h4}) $display("FAIL lw_fields got %0h want %0h", {ID_EX_vld, ID_EX_mem_cmd, ID_EX_rd, ID_EX_alu_opb}, {1'b1, `BUS_READ, 5'd3, 32'h4}); else pass++;
    drive(32'h00118233, 32'h114, 32'h1, 32'h2);
    total++; if (ID_stall !== 1'b1) $display("FAIL hz_stall got %0h want 1", ID_stall); else pass++;
    tick;
    total++; if ({ID_EX_vld, ID_EX_mem_cmd, ID_EX_rd} !== {1'b0, `BUS_NONE, 5'd0}) $display("FAIL hz_bubble got %0h want 0", {ID_EX_vld, ID_EX_mem_cmd, ID_EX_rd}); else pass++;
    total++; if (ID_stall !== 1'b0) $display("FAIL hz_release got %0h want 0", ID_stall); else pass++;
    tick;
    total++; if ({ID_EX_vld, ID_EX_rd, ID_EX_alu_func, ID_EX_pc} !== {1'b1, 5'd4, `ALU_ADD, 32'h114}) $display("FAIL add_after got %0h want %0h", {ID_EX_vld, ID_EX_rd, ID_EX_alu_func, ID_EX_pc}, {1'b1, 5'd4, `ALU_ADD, 32'h114}); else pass++;
    drive(32'h00012003, 32'h118, 32'h0, 32'h0);
    tick;
    drive(32'h00100233, 32'h11C, 32'h0, 32'h0);
    total++; if (ID_stall !== 1'b0) $display("FAIL x0_stall got %0h want 0", ID_stall); else pass++;
    tick;
  endtask

  task automatic test_store_backpressure;
    EX_ready = 0;
    drive(32'h00732423, 32'h120, 32'h30, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      total++; if (ID_stall !== 1'b1) $display("FAIL bp_stall%0d got %0h want 1", i, ID_stall); else pass++;
      tick;
      total++; if ({ID_EX_vld, ID_EX_rd, ID_EX_pc} !== {1'b1, 5'd4, 32'h11C}) $display("FAIL bp_hold%0d got %0h want %0h", i, {ID_EX_vld, ID_EX_rd, ID_EX_pc}, {1'b1, 5'd4, 32'h11C}); else pass++;
    end
    EX_ready = 1;
    #1;
    total++; if (ID_stall !== 1'b0) $display("FAIL bp_go got %0h want 0", ID_stall); else pass++;
    tick;
    total++; if ({ID_EX_mem_cmd, ID_EX_mem_din, ID_EX_alu_opb, ID_EX_rd} !== {`BUS_WRITE, 32'hDEADBEEF, 32'h8, 5'd0}) $display("FAIL sw got %0h want %0h", {ID_EX_mem_cmd, ID_EX_mem_din, ID_EX_alu_opb, ID_EX_rd}, {`BUS_WRITE, 32'hDEADBEEF, 32'h8, 5'd0}); else pass++;
    total++; if (ID_EX_alu_opa !== 32'h30) $display("FAIL sw_opa got %0h want 30", ID_EX_alu_opa); else pass++;
  endtask

  task automatic test_flush;
    EX_ready = 0; flush = 1;
    drive(32'h123454B7, 32'h124, 32'h0, 32'h0);
    total++; if (ID_stall !== 1'b0) $display("FAIL flush_stall got %0h want 0", ID_stall); else pass++;
    tick;
    total++; if ({ID_EX_vld, ID_EX_mem_cmd} !== {1'b0, `BUS_NONE}) $display("FAIL flush_clr got %0h want 0", {ID_EX_vld, ID_EX_mem_cmd}); else pass++;
    flush = 0; EX_ready = 1;
    tick;
    total++; if ({ID_EX_vld, ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_rd} !== {1'b1, 32'h0, 32'h12345000, 5'd9}) $display("FAIL lui got %0h want %0h", {ID_EX_vld, ID_EX_alu_opa, ID_EX_alu_opb, ID_EX_rd}, {1'b1, 32'h0, 32'h12345000, 5'd9}); else pass++;
  endtask

  task automatic test_illegal;
    drive(32'h0000007F, 32'h128, 32'h0, 32'h0);
    tick;
`ifdef ID_ILLEGAL_TRAP_EN
    total++; if ({ID_EX_vld, ID_EX_illegal, ID_EX_mem_cmd, ID_EX_rd} !== {1'b1, 1'b1, `BUS_NONE, 5'd0}) $display("FAIL ill got %0h want %0h", {ID_EX_vld, ID_EX_illegal, ID_EX_mem_cmd, ID_EX_rd}, {1'b1, 1'b1, `BUS_NONE, 5'd0}); else pass++;
`else
    total++; if ({ID_EX_vld, ID_EX_illegal} !== 2'b00) $display("FAIL ill got %0h want 0", {ID_EX_vld, ID_EX_illegal}); else pass++;
`endif
  endtask

  task automatic test_reset_mid_stall;
    drive(32'h00412183, 32'h130, 32'h20, 32'h0);
    tick;
    drive(32'h00118233, 32'h134, 32'h1, 32'h2);
    total++; if (ID_stall !== 1'b1) $display("FAIL rms_pre got %0h want 1", ID_stall); else pass++;
    rst = 1;
    tick;
    total++; if ({ID_stall, ID_EX_vld, ID_EX_pc, ID_EX_rd} !== {1'b0, 1'b0, 32'h80, 5'd0}) $display("FAIL rms_post got %0h want %0h", {ID_stall, ID_EX_vld, ID_EX_pc, ID_EX_rd}, {1'b0, 1'b0, 32'h80, 5'd0}); else pass++;
    rst = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_alu_ops;
    test_load_use;
    test_store_backpressure;
    test_flush;
    test_illegal;
    test_reset_mid_stall;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/id_ex_decode.md
Name: id_ex_decode

Overview:
Next-generation decode stage with a registered ID/EX pipeline boundary.
- Decodes an RV32I subset: OP, OP-IMM, LUI, AUIPC, LOAD, STORE.
- Builds ALU operands, ALU function, memory command and destination register.
- Holds the result in an output register that obeys a downstream ready handshake.
- Detects load-use hazards against the instruction in the ID/EX register and inserts a bubble.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, datapath width of PC, operands and store data.
- NREG_BITS, 5, register-index width.
- RESET_PC, 0, value loaded into ID_EX_pc on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- RF_rs1_data  in  XLEN  register-file read data for rs1.
- RF_rs2_data  in  XLEN  register-file read data for rs2.
- IF_ID_pc  in  XLEN  PC of the incoming instruction.
- IF_ID_inst  in  32  incoming instruction.
- IF_ID_vld  in  1  incoming instruction is valid.
- EX_ready  in  1  EX stage accepts the ID/EX register contents this cycle.
- flush  in  1  squash the current decode and the ID/EX register.
- ID_rs1  out  NREG_BITS  inst[19:15], combinational.
- ID_rs2  out  NREG_BITS  inst[24:20], combinational.
- ID_stall  out  1  IF/ID must hold its contents.
- ID_EX_vld  out  1  ID/EX register holds a valid instruction.
- ID_EX_pc  out  XLEN  registered PC.
- ID_EX_alu_opa  out  XLEN  registered operand A.
- ID_EX_alu_opb  out  XLEN  registered operand B.
- ID_EX_alu_func  out  5  registered `ALU_* code.
- ID_EX_mem_din  out  XLEN  registered store data.
- ID_EX_mem_cmd  out  2  registered `BUS_NONE / `BUS_READ / `BUS_WRITE.
- ID_EX_rd  out  NREG_BITS  registered destination; 0 when there is no writeback.
- ID_EX_illegal  out  1  registered illegal-instruction flag (see Optional Feature).

Behaviour:
- Reset:
  - All ID_EX_* outputs go to 0, except ID_EX_pc=RESET_PC and ID_EX_mem_cmd=`BUS_NONE.
  - ID_stall is 0 during reset.
- Decode (combinational, from IF_ID_inst):
  - OP: opa=rs1 data, opb=rs2 data; func from funct3/funct7: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: opb=sign-extended I-immediate. SRAI is selected by inst[30]. SLLI/SRLI/SRAI use shamt=inst[24:20].
  - LUI: opa=0, opb={inst[31:12],12'b0}, ADD.
  - AUIPC: opa=IF_ID_pc, opb=U-immediate, ADD.
  - LOAD: opa=rs1 data, opb=I-immediate, ADD, mem_cmd=`BUS_READ.
  - STORE: opa=rs1 data, opb=S-immediate, ADD, mem_cmd=`BUS_WRITE, mem_din=rs2 data, rd=0.
  - Any opcode outside the subset is illegal.
- Operand usage:
  - rs1 is used by OP, OP-IMM, LOAD, STORE.
  - rs2 is used by OP and STORE.
- Load-use hazard (hz) is true when all of the following hold:
  - IF_ID_vld and ID_EX_vld are both 1.
  - ID_EX_mem_cmd==`BUS_READ.
  - ID_EX_rd!=0.
  - ID_EX_rd equals a used rs1 or a used rs2.
- Register update, one cycle latency, with adv = !ID_EX_vld | EX_ready:
  - rst: reset values.
  - else flush: ID_EX_vld<=0, mem_cmd<=`BUS_NONE.
  - else adv & hz: bubble. ID_EX_vld<=0, mem_cmd<=`BUS_NONE, rd<=0.
  - else adv: load the decoded fields. ID_EX_vld<=IF_ID_vld. If !IF_ID_vld, mem_cmd<=`BUS_NONE and rd<=0.
  - else (!adv): hold all fields.
- Stall: ID_stall = IF_ID_vld & !flush & (hz | !adv).
- Flush has priority over both hazard and stall. Flush asserted together with !EX_ready still clears the register.
- Back-to-back loads: each dependent consumer stalls exactly one cycle.
- Writes to x0: rd field of 0 is kept; it never matches in hazard detection.
- Reset asserted mid-stall: the next cycle shows reset values and ID_stall=0.

Optional Feature:
- Macro: ID_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal valid instruction loads ID_EX_vld=1 and ID_EX_illegal=1.
  - mem_cmd=`BUS_NONE and rd=0, so the instruction has no side effects.
  - It participates in the handshake like any other instruction.
- Not defined:
  - An illegal instruction becomes a bubble (ID_EX_vld=0).
  - ID_EX_illegal is tied to 0.

Test Plan:
- Reset: hold rst 2 cycles with arbitrary inputs -> all ID_EX_* at reset values, ID_EX_pc=RESET_PC, ID_stall=0.
- ADDI x5,x1,-3 with rs1 data 0x10, EX_ready=1 -> next cycle ID_EX_vld=1, opa=0x10, opb=0xFFFFFFFD, func=`ALU_ADD, rd=5.
- LW x3,4(x2) followed by ADD x4,x3,x1 -> one cycle with ID_stall=1 and a bubble (ID_EX_vld=0); the ADD then enters with rd=4.
- SW x7,8(x6) with rs2 data 0xDEADBEEF -> mem_cmd=`BUS_WRITE, mem_din=0xDEADBEEF, opb=8, rd=0.
- EX_ready=0 for 3 cycles with a valid ID/EX register -> ID/EX fields unchanged and ID_stall=1; the register advances on the first cycle EX_ready=1.
- flush together with LUI x9,0x12345 and EX_ready=0 -> ID_EX_vld=0 next cycle. Illegal opcode 0x7F -> ID_EX_illegal=1 with macro, bubble without.
